// File: rtl/btn_conditioner.sv
// Five-channel push-button conditioner: two-flop synchronizer, per-channel debounce,
// press/release pulses and an optional auto-repeat engine.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_RATE     = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_raw,
  input  logic [4:0] repeat_en,
  output logic [4:0] btn_level,
  output logic [4:0] btn_press,
  output logic [4:0] btn_release
);

  localparam int unsigned NCH  = 5;
  localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DLY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST = TW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;
    logic [TW-1:0] timer;
    rpt_state_t    state;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          settle;
    logic          rise;
    logic          fall;
    logic          hold;

    // Level flips on the edge where the differing run would reach DEBOUNCE_CYCLES
    assign settle = (sync != level_q) && (cnt == DB_LAST);
    assign rise   = settle && !level_q;
    assign fall   = settle && level_q;
    // A falling edge cancels repeats in the same cycle so press and release never overlap
    assign hold   = level_q && !fall && repeat_en[i];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        meta      <= 1'b0;
        sync      <= 1'b0;
        cnt       <= '0;
        timer     <= '0;
        state     <= IDLE;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        meta      <= btn_raw[i];
        sync      <= meta;
        press_q   <= 1'b0;
        release_q <= 1'b0;

        if (sync == level_q) begin
          cnt <= '0;
        end else if (settle) begin
          cnt       <= '0;
          level_q   <= !level_q;
          press_q   <= rise;
          release_q <= fall;
        end else begin
          cnt <= cnt + CW'(1);
        end

        unique case (state)
          IDLE: begin
            timer <= '0;
            if (rise && repeat_en[i]) state <= DELAY;
          end
          DELAY: begin
            if (!hold) begin
              state <= IDLE;
              timer <= '0;
            end else if (timer == DLY_LAST) begin
              press_q <= 1'b1;
              timer   <= '0;
              state   <= REPEAT;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          REPEAT: begin
            if (!hold) begin
              state <= IDLE;
              timer <= '0;
            end else if (timer == RATE_LAST) begin
              press_q <= 1'b1;
              timer   <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          default: begin
            state <= IDLE;
            timer <= '0;
          end
        endcase
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed table-driven bench for btn_conditioner (DEBOUNCE=4, DELAY=20, RATE=8).
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn_raw;
  logic [4:0] repeat_en;
  logic [4:0] btn_level;
  logic [4:0] btn_press;
  logic [4:0] btn_release;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0] raw;
    logic [4:0] en;
    logic [4:0] lvl;
    logic [4:0] prs;
    logic [4:0] rel;
  } vec_t;

  vec_t tbl[$];

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .repeat_en  (repeat_en),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  function automatic void add(int n, logic [4:0] raw, logic [4:0] en,
                              logic [4:0] lvl, logic [4:0] prs, logic [4:0] rel);
    vec_t v;
    v.raw = raw; v.en = en; v.lvl = lvl; v.prs = prs; v.rel = rel;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  task automatic check(string name, int idx, logic [4:0] lvl, logic [4:0] prs, logic [4:0] rel);
    n_cmp++;
    if ({btn_level, btn_press, btn_release} !== {lvl, prs, rel}) begin
      n_bad++;
      $display("FAIL %s[%0d]: got lvl=%b prs=%b rel=%b, want lvl=%b prs=%b rel=%b",
               name, idx, btn_level, btn_press, btn_release, lvl, prs, rel);
    end
  endtask

  // Inputs change at negedge, get sampled on the next posedge, outputs checked at the following negedge
  task automatic run_table(string name);
    for (int k = 0; k < tbl.size(); k++) begin
      btn_raw   = tbl[k].raw;
      repeat_en = tbl[k].en;
      @(posedge clk);
      @(negedge clk);
      check(name, k, tbl[k].lvl, tbl[k].prs, tbl[k].rel);
    end
    tbl.delete();
  endtask

  initial begin
    rst       = 1'b0;
    btn_raw   = 5'd0;
    repeat_en = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", 0, 5'd0, 5'd0, 5'd0);
    rst = 1'b1;
    add(3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    run_table("idle");

    // Centre press, no repeat
    add(5,  5'd1, 5'd0, 5'd0, 5'd0, 5'd0);
    add(1,  5'd1, 5'd0, 5'd1, 5'd1, 5'd0);
    add(10, 5'd1, 5'd0, 5'd1, 5'd0, 5'd0);
    add(5,  5'd0, 5'd0, 5'd1, 5'd0, 5'd0);
    add(1,  5'd0, 5'd0, 5'd0, 5'd0, 5'd1);
    add(4,  5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    run_table("press_c");

    // Three-cycle glitch on L is rejected
    add(3, 5'd8, 5'd0, 5'd0, 5'd0, 5'd0);
    add(8, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    run_table("glitch_l");

    // R held 60 cycles with auto-repeat; last repeat slot coincides with the release edge
    add(5,  5'd16, 5'd16, 5'd0,  5'd0,  5'd0);
    add(1,  5'd16, 5'd16, 5'd16, 5'd16, 5'd0);
    add(19, 5'd16, 5'd16, 5'd16, 5'd0,  5'd0);
    for (int r = 0; r < 4; r++) begin
      add(1, 5'd16, 5'd16, 5'd16, 5'd16, 5'd0);
      add(7, 5'd16, 5'd16, 5'd16, 5'd0,  5'd0);
    end
    add(1, 5'd16, 5'd16, 5'd16, 5'd16, 5'd0);
    add(2, 5'd16, 5'd16, 5'd16, 5'd0,  5'd0);
    add(5, 5'd0,  5'd16, 5'd16, 5'd0,  5'd0);
    add(1, 5'd0,  5'd16, 5'd0,  5'd0,  5'd16);
    add(4, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0);
    run_table("repeat_r");

    // U and D together
    add(5, 5'd6, 5'd0, 5'd0, 5'd0, 5'd0);
    add(1, 5'd6, 5'd0, 5'd6, 5'd6, 5'd0);
    add(3, 5'd6, 5'd0, 5'd6, 5'd0, 5'd0);
    add(5, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0);
    add(1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd6);
    add(3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    run_table("dual_ud");

    // C bounces, then settles high
    for (int i = 0; i < 20; i++)
      add(1, ((i % 4) < 2) ? 5'd1 : 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    add(5, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0);
    add(1, 5'd1, 5'd0, 5'd1, 5'd1, 5'd0);
    add(4, 5'd1, 5'd0, 5'd1, 5'd0, 5'd0);
    add(5, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0);
    add(1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1);
    add(3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    run_table("bounce_c");

    // U in DELAY: dropping repeat_en cancels, re-enabling while held does not restart
    add(5,  5'd2, 5'd2, 5'd0, 5'd0, 5'd0);
    add(1,  5'd2, 5'd2, 5'd2, 5'd2, 5'd0);
    add(4,  5'd2, 5'd2, 5'd2, 5'd0, 5'd0);
    add(2,  5'd2, 5'd0, 5'd2, 5'd0, 5'd0);
    add(18, 5'd2, 5'd2, 5'd2, 5'd0, 5'd0);
    add(5,  5'd0, 5'd2, 5'd2, 5'd0, 5'd0);
    add(1,  5'd0, 5'd2, 5'd0, 5'd0, 5'd2);
    add(3,  5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    run_table("en_drop_u");

    // L into REPEAT, then reset mid-repeat
    add(5,  5'd8, 5'd8, 5'd0, 5'd0, 5'd0);
    add(1,  5'd8, 5'd8, 5'd8, 5'd8, 5'd0);
    add(19, 5'd8, 5'd8, 5'd8, 5'd0, 5'd0);
    add(1,  5'd8, 5'd8, 5'd8, 5'd8, 5'd0);
    add(3,  5'd8, 5'd8, 5'd8, 5'd0, 5'd0);
    run_table("pre_rst_l");

    rst       = 1'b0;
    repeat_en = 5'd0;
    #1;
    check("rst_async", 0, 5'd0, 5'd0, 5'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hold", 0, 5'd0, 5'd0, 5'd0);
    rst = 1'b1;

    add(5,  5'd8, 5'd0, 5'd0, 5'd0, 5'd0);
    add(1,  5'd8, 5'd0, 5'd8, 5'd8, 5'd0);
    add(30, 5'd8, 5'd0, 5'd8, 5'd0, 5'd0);
    add(5,  5'd0, 5'd0, 5'd8, 5'd0, 5'd0);
    add(1,  5'd0, 5'd0, 5'd0, 5'd0, 5'd8);
    add(3,  5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    run_table("post_rst_l");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the consecutive cycles a synchronized input must differ from its debounced level before that level changes; legal minimum 1.
REQ-002 Parameter REPEAT_DELAY, default 50000000, SHALL set the cycles from a press pulse to the first auto-repeat pulse; legal minimum 1.
REQ-003 Parameter REPEAT_RATE, default 10000000, SHALL set the cycles between subsequent auto-repeat pulses; legal minimum 1.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 btn_raw  input  5  SHALL carry asynchronous raw buttons: bit0 C, bit1 U, bit2 D, bit3 L, bit4 R; 1 = pressed.
REQ-007 repeat_en  input  5  SHALL enable auto-repeat per channel; synchronous to clk.
REQ-008 btn_level  output  5  SHALL carry the debounced, registered button levels.
REQ-009 btn_press  output  5  SHALL carry one-cycle pulses for each press and each auto-repeat event.
REQ-010 btn_release  output  5  SHALL carry one-cycle pulses for each debounced release.

Function
REQ-011 Each channel SHALL pass btn_raw through a two-flop synchronizer before any other logic; the second flop output is "sync".
REQ-012 Each channel SHALL hold a debounce counter sized ceil(log2(DEBOUNCE_CYCLES+1)) bits.
REQ-013 When sync equals btn_level, the counter SHALL clear to 0 on the next edge.
REQ-014 When sync differs from btn_level, the counter SHALL increment; on the edge where it would reach DEBOUNCE_CYCLES, btn_level SHALL toggle and the counter SHALL clear.
REQ-015 Latency: a clean raw rise sampled at edge k SHALL make btn_level 1 at edge k+1+DEBOUNCE_CYCLES (2 sync edges, then DEBOUNCE_CYCLES counting edges overlapping the second); a falling edge has identical latency.
REQ-016 A raw glitch producing fewer than DEBOUNCE_CYCLES consecutive differing sync samples SHALL NOT change btn_level or produce any pulse.
REQ-017 btn_press[i] SHALL be 1 for exactly the one cycle in which btn_level[i] first reads 1; btn_release[i] likewise for the first cycle btn_level[i] reads 0.
REQ-018 Each channel SHALL have a repeat FSM with states IDLE, DELAY, REPEAT and a repeat timer sized for max(REPEAT_DELAY, REPEAT_RATE).
REQ-019 IDLE->DELAY, timer cleared, in the cycle btn_press fires from a level rise while repeat_en[i]=1.
REQ-020 In DELAY, when the timer reaches REPEAT_DELAY-1, the FSM SHALL emit one btn_press pulse on the next cycle, clear the timer and enter REPEAT.
REQ-021 In REPEAT, when the timer reaches REPEAT_RATE-1, the FSM SHALL emit one btn_press pulse on the next cycle and clear the timer, remaining in REPEAT.
REQ-022 From DELAY or REPEAT, btn_level[i]=0 or repeat_en[i]=0 SHALL force IDLE with the timer cleared on the next edge; no repeat pulse SHALL be emitted in that cycle.
REQ-023 Reasserting repeat_en[i] while held SHALL NOT start repeats; a new debounced press is required.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-025 btn_press and btn_release SHALL never both be 1 on the same channel in the same cycle.

Reset
REQ-026 rst=0 SHALL asynchronously clear synchronizer flops, counters, timers, btn_level, btn_press and btn_release to 0 and put every FSM in IDLE.
REQ-027 Deassertion of rst SHALL take effect on the next rising clk edge; a button held through reset SHALL produce a press after the full REQ-015 latency, counted from the first post-reset edge.
REQ-028 Reset asserted mid-debounce or mid-repeat SHALL discard all progress; no pulse SHALL be emitted after release of reset for that earlier activity.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8)
REQ-029 Raw bit0 rises and holds, repeat_en=0 -> btn_level[0]=1 exactly 5 edges later, btn_press[0] one cycle, no further pulses.
REQ-030 Raw bit3 glitches high for 3 cycles -> btn_level, btn_press and btn_release stay 0.
REQ-031 Raw bit4 held 60 cycles, repeat_en[4]=1 -> press pulse, repeat pulse 20 cycles later, then one every 8 cycles until release; release pulse 5 edges after the raw fall.
REQ-032 Bits 1 and 2 rise on the same edge -> btn_press[1] and btn_press[2] pulse in the same cycle.
REQ-033 rst=0 asserted while bit3 is in REPEAT -> all outputs 0 immediately; after reset, with bit3 still held, one press pulse 5 edges later, then no repeats unless repeat_en[3]=1 at that press.
REQ-034 Raw bit0 bounces 1/0 every 2 cycles for 20 cycles, then settles high -> exactly one btn_press[0], 5 edges after settling.
